// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode/issue stage in front of the EX-stage ALU. Decodes RV32I R-type and
//   I-type ALU instructions into a 4-bit ALU select code. Builds the operands
//   from the register file, the immediate generator and EX/MEM forwarding, then
//   registers them in the ID/EX pipeline register (1-cycle latency). A DIV is
//   held stable at the ALU for DIV_CYCLES cycles, and fetch is back-pressured
//   through ready while it is held.
//
//   Optional feature: define ALU_ISSUE_MULDIV_EN to decode MUL (single cycle)
//   and DIV (multi-cycle hold). When the macro is undefined, f7=0000001 is
//   illegal, the hold state is never entered and busy is tied to 0.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   if_valid     in   instr/rs1_data/rs2_data are valid this cycle
//   instr        in   32-bit instruction word
//   rs1_data     in   register-file read port 1
//   rs2_data     in   register-file read port 2
//   stall        in   downstream hazard stall; freezes the ID/EX register
//   flush        in   branch/trap flush; kills the ID/EX contents
//   exmem_we     in   EX/MEM stage writes a register
//   exmem_rd     in   EX/MEM destination register
//   exmem_result in   EX/MEM result (forwarding source)
//   ready        out  instr is consumed when if_valid && ready
//   idex_valid   out  ID/EX holds a live op
//   data1        out  ALU operand 1
//   data2        out  ALU operand 2 (rs2 or imm/shamt)
//   select       out  ALU op code
//   rd           out  destination register
//   reg_write    out  writeback enable (0 when rd==0)
//   busy         out  multi-cycle op in progress
//   illegal      out  one-cycle pulse when an unsupported instruction is consumed
module alu_issue_stage #(
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_we,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  output logic        ready,
  output logic        idex_valid,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [3:0]  select,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        busy,
  output logic        illegal
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_XOR = 4'b0011;
  localparam logic [3:0] SEL_SLL = 4'b0100;
  localparam logic [3:0] SEL_SRL = 4'b0101;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SRA = 4'b0111;
`ifdef ALU_ISSUE_MULDIV_EN
  localparam logic [3:0] SEL_MUL = 4'b1000;
  localparam logic [3:0] SEL_DIV = 4'b1001;
`endif

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  // Counter load value; the hold lasts cnt_init+1 cycles.
  localparam logic [3:0] CNT_INIT = 4'(DIV_CYCLES - 1);

  // Instruction fields
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  // Registered state
  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        idex_valid_q, idex_valid_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] data2_q, data2_d;
  logic [3:0]  select_q, select_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        illegal_q, illegal_d;

  // Decode results
  logic        legal;
  logic        is_div;
  logic        use_imm;
  logic        use_shamt;
  logic [3:0]  dec_sel;

  always_comb begin
    legal     = 1'b0;
    is_div    = 1'b0;
    use_imm   = 1'b0;
    use_shamt = 1'b0;
    dec_sel   = SEL_ADD;
    if (opc == OPC_R) begin
      case (f7)
        7'b0000000: begin
          legal = 1'b1;
          case (f3)
            3'b000:  dec_sel = SEL_ADD;
            3'b001:  dec_sel = SEL_SLL;
            3'b100:  dec_sel = SEL_XOR;
            3'b101:  dec_sel = SEL_SRL;
            3'b110:  dec_sel = SEL_OR;
            3'b111:  dec_sel = SEL_AND;
            default: legal   = 1'b0;  // SLT/SLTU
          endcase
        end
        7'b0100000: begin
          legal = 1'b1;
          case (f3)
            3'b000:  dec_sel = SEL_SUB;
            3'b101:  dec_sel = SEL_SRA;
            default: legal   = 1'b0;
          endcase
        end
`ifdef ALU_ISSUE_MULDIV_EN
        7'b0000001: begin
          legal = 1'b1;
          case (f3)
            3'b000:  dec_sel = SEL_MUL;
            3'b100: begin
              dec_sel = SEL_DIV;
              is_div  = 1'b1;
            end
            default: legal = 1'b0;
          endcase
        end
`endif
        default: legal = 1'b0;
      endcase
    end else if (opc == OPC_I) begin
      use_imm = 1'b1;
      legal   = 1'b1;
      case (f3)
        3'b000: dec_sel = SEL_ADD;
        3'b100: dec_sel = SEL_XOR;
        3'b110: dec_sel = SEL_OR;
        3'b111: dec_sel = SEL_AND;
        3'b001: begin
          dec_sel   = SEL_SLL;
          use_shamt = 1'b1;
          legal     = (f7 == 7'b0000000);
        end
        3'b101: begin
          use_shamt = 1'b1;
          if (f7 == 7'b0000000) begin
            dec_sel = SEL_SRL;
          end else if (f7 == 7'b0100000) begin
            dec_sel = SEL_SRA;
          end else begin
            legal = 1'b0;
          end
        end
        default: legal = 1'b0;  // SLTI/SLTIU
      endcase
    end
  end

  // Operand build with EX/MEM forwarding (x0 is never forwarded)
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] op2;

  assign rs1_val = (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs1)) ? exmem_result : rs1_data;
  assign rs2_val = (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs2)) ? exmem_result : rs2_data;
  assign imm     = use_shamt ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
  assign op2     = use_imm ? imm : rs2_val;

  assign ready = (state_q == IDLE) && !stall;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idex_valid_d = idex_valid_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    select_d     = select_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    illegal_d    = 1'b0;  // pulse, never held

    if (state_q == IDLE) begin
      if (flush) begin
        idex_valid_d = 1'b0;
      end else if (stall) begin
        // freeze ID/EX
      end else if (if_valid && legal) begin
        idex_valid_d = 1'b1;
        data1_d      = rs1_val;
        data2_d      = op2;
        select_d     = dec_sel;
        rd_d         = instr[11:7];
        reg_write_d  = (instr[11:7] != 5'd0);
        if (is_div) begin
          state_d = HOLD;
          cnt_d   = CNT_INIT;
        end
      end else if (if_valid) begin
        idex_valid_d = 1'b0;
        illegal_d    = 1'b1;
      end else begin
        idex_valid_d = 1'b0;
      end
    end else begin
      // HOLD: stall is ignored, the counter keeps running
      if (flush || (cnt_q == 4'd0)) begin
        state_d      = IDLE;
        cnt_d        = 4'd0;
        idex_valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idex_valid_q <= 1'b0;
      data1_q      <= 32'd0;
      data2_q      <= 32'd0;
      select_q     <= 4'd0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idex_valid_q <= idex_valid_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      select_q     <= select_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      illegal_q    <= illegal_d;
    end
  end

  assign idex_valid = idex_valid_q;
  assign data1      = data1_q;
  assign data2      = data2_q;
  assign select     = select_q;
  assign rd         = rd_q;
  assign reg_write  = reg_write_q;
  assign illegal    = illegal_q;

`ifdef ALU_ISSUE_MULDIV_EN
  assign busy = (state_q == HOLD);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        exmem_we = 1'b0;
  logic [4:0]  exmem_rd = 5'd0;
  logic [31:0] exmem_result = 32'd0;
  logic        ready;
  logic        idex_valid;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  select;
  logic [4:0]  rd;
  logic        reg_write;
  logic        busy;
  logic        illegal;

  int n_checks = 0;
  int n_fail = 0;

  alu_issue_stage #(.DIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .flush(flush),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .ready(ready), .idex_valid(idex_valid), .data1(data1), .data2(data2),
    .select(select), .rd(rd), .reg_write(reg_write), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'b0110011};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr = ins; rs1_data = a; rs2_data = b; if_valid = 1'b1;
    step();
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    if (idex_valid !== 1'b0) begin $display("FAIL rst_valid got %b want 0", idex_valid); n_fail++; end
    n_checks++;
    if (data1 !== 32'd0 || data2 !== 32'd0) begin
      $display("FAIL rst_data got %h/%h want 0/0", data1, data2); n_fail++;
    end
    n_checks++;
    if (select !== 4'd0 || rd !== 5'd0 || reg_write !== 1'b0) begin
      $display("FAIL rst_ctl got sel=%b rd=%0d we=%b want 0", select, rd, reg_write); n_fail++;
    end
    n_checks++;
    if (busy !== 1'b0 || illegal !== 1'b0) begin
      $display("FAIL rst_flags got busy=%b ill=%b want 0/0", busy, illegal); n_fail++;
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (ready !== 1'b1) begin $display("FAIL rst_ready got %b want 1", ready); n_fail++; end
    n_checks++;
  endtask

  task automatic test_rtype();
    issue(32'h002081B3, 32'd5, 32'd7);  // ADD x3,x1,x2
    if (select !== 4'b0010 || data1 !== 32'd5 || data2 !== 32'd7) begin
      $display("FAIL add_ops got sel=%b d1=%h d2=%h want 0010/5/7", select, data1, data2); n_fail++;
    end
    n_checks++;
    if (rd !== 5'd3 || reg_write !== 1'b1 || idex_valid !== 1'b1) begin
      $display("FAIL add_ctl got rd=%0d we=%b v=%b want 3/1/1", rd, reg_write, idex_valid); n_fail++;
    end
    n_checks++;
    step();  // bubble
    if (idex_valid !== 1'b0) begin $display("FAIL bubble got %b want 0", idex_valid); n_fail++; end
    n_checks++;
    issue(rtype(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd6), 32'h1, 32'h2);  // SLL
    if (select !== 4'b0100) begin $display("FAIL sll got %b want 0100", select); n_fail++; end
    n_checks++;
    issue(rtype(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd6), 32'h1, 32'h2);  // XOR
    if (select !== 4'b0011) begin $display("FAIL xor got %b want 0011", select); n_fail++; end
    n_checks++;
    issue(rtype(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd6), 32'h1, 32'h2);  // SRL
    if (select !== 4'b0101) begin $display("FAIL srl got %b want 0101", select); n_fail++; end
    n_checks++;
    issue(rtype(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd6), 32'h1, 32'h2);  // OR
    if (select !== 4'b0001) begin $display("FAIL or got %b want 0001", select); n_fail++; end
    n_checks++;
    issue(rtype(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd6), 32'h1, 32'h2);  // AND
    if (select !== 4'b0000) begin $display("FAIL and got %b want 0000", select); n_fail++; end
    n_checks++;
    issue(rtype(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd6), 32'h1, 32'h2);  // SRA
    if (select !== 4'b0111) begin $display("FAIL sra got %b want 0111", select); n_fail++; end
    n_checks++;
    issue(rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 32'h1, 32'h2);  // ADD x0
    if (idex_valid !== 1'b1 || rd !== 5'd0 || reg_write !== 1'b0) begin
      $display("FAIL rd0 got v=%b rd=%0d we=%b want 1/0/0", idex_valid, rd, reg_write); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_itype();
    issue(32'hFFF00093, 32'h10, 32'h99);  // ADDI x1,x0,-1
    if (data2 !== 32'hFFFFFFFF || select !== 4'b0010 || data1 !== 32'h10) begin
      $display("FAIL addi got d1=%h d2=%h sel=%b want 10/ffffffff/0010", data1, data2, select);
      n_fail++;
    end
    n_checks++;
    issue(32'h4040D093, 32'h80000000, 32'h99);  // SRAI x1,x1,4
    if (select !== 4'b0111 || data2 !== 32'd4 || rd !== 5'd1) begin
      $display("FAIL srai got sel=%b d2=%h rd=%0d want 0111/4/1", select, data2, rd); n_fail++;
    end
    n_checks++;
    issue({12'h800, 5'd1, 3'b110, 5'd2, 7'b0010011}, 32'h3, 32'h99);  // ORI x2,x1,-2048
    if (select !== 4'b0001 || data2 !== 32'hFFFFF800) begin
      $display("FAIL ori got sel=%b d2=%h want 0001/fffff800", select, data2); n_fail++;
    end
    n_checks++;
    issue({7'b0000000, 5'd31, 5'd1, 3'b001, 5'd2, 7'b0010011}, 32'h3, 32'h99);  // SLLI 31
    if (select !== 4'b0100 || data2 !== 32'd31) begin
      $display("FAIL slli got sel=%b d2=%h want 0100/1f", select, data2); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_forward();
    exmem_we = 1'b1; exmem_rd = 5'd1; exmem_result = 32'hA5;
    issue(rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5), 32'h11, 32'h22);  // SUB x5,x1,x2
    if (data1 !== 32'hA5 || data2 !== 32'h22 || select !== 4'b0110) begin
      $display("FAIL fwd_rs1 got d1=%h d2=%h sel=%b want a5/22/0110", data1, data2, select);
      n_fail++;
    end
    n_checks++;
    exmem_rd = 5'd2;
    issue(rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5), 32'h11, 32'h22);
    if (data1 !== 32'h11 || data2 !== 32'hA5) begin
      $display("FAIL fwd_rs2 got d1=%h d2=%h want 11/a5", data1, data2); n_fail++;
    end
    n_checks++;
    exmem_rd = 5'd0;
    issue(rtype(7'b0100000, 5'd2, 5'd0, 3'b000, 5'd5), 32'h11, 32'h22);  // rs1=x0
    if (data1 !== 32'h11) begin $display("FAIL fwd_x0 got %h want 11", data1); n_fail++; end
    n_checks++;
    exmem_we = 1'b0; exmem_rd = 5'd1;
    issue(rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5), 32'h33, 32'h22);
    if (data1 !== 32'h33) begin $display("FAIL fwd_nowe got %h want 33", data1); n_fail++; end
    n_checks++;
    exmem_rd = 5'd0;
  endtask

  task automatic test_illegal();
    issue(32'h0020A1B3, 32'h1, 32'h2);  // SLT
    if (illegal !== 1'b1 || idex_valid !== 1'b0) begin
      $display("FAIL slt got ill=%b v=%b want 1/0", illegal, idex_valid); n_fail++;
    end
    n_checks++;
    step();
    if (illegal !== 1'b0) begin $display("FAIL ill_pulse got %b want 0", illegal); n_fail++; end
    n_checks++;
    issue({12'h005, 5'd1, 3'b010, 5'd2, 7'b0010011}, 32'h1, 32'h2);  // SLTI
    if (illegal !== 1'b1) begin $display("FAIL slti got %b want 1", illegal); n_fail++; end
    n_checks++;
`ifndef ALU_ISSUE_MULDIV_EN
    issue(32'h0220C233, 32'h1, 32'h2);  // DIV without M extension
    if (illegal !== 1'b1 || busy !== 1'b0 || idex_valid !== 1'b0) begin
      $display("FAIL div_off got ill=%b busy=%b v=%b want 1/0/0", illegal, busy, idex_valid);
      n_fail++;
    end
    n_checks++;
    issue(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), 32'h1, 32'h2);  // MUL
    if (illegal !== 1'b1) begin $display("FAIL mul_off got %b want 1", illegal); n_fail++; end
    n_checks++;
`endif
    step();
  endtask

  task automatic test_stall_flush();
    issue(32'h002081B3, 32'd5, 32'd7);
    stall = 1'b1;
    instr = rtype(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd9); rs1_data = 32'h77; if_valid = 1'b1;
    step();
    if (ready !== 1'b0) begin $display("FAIL stall_ready got %b want 0", ready); n_fail++; end
    n_checks++;
    if (select !== 4'b0010 || data1 !== 32'd5 || rd !== 5'd3 || idex_valid !== 1'b1) begin
      $display("FAIL stall_hold got sel=%b d1=%h rd=%0d v=%b want 0010/5/3/1",
               select, data1, rd, idex_valid);
      n_fail++;
    end
    n_checks++;
    stall = 1'b0; flush = 1'b1;  // flush beats a valid instruction
    step();
    if (idex_valid !== 1'b0) begin $display("FAIL flush got %b want 0", idex_valid); n_fail++; end
    n_checks++;
    flush = 1'b0; if_valid = 1'b0;
  endtask

`ifdef ALU_ISSUE_MULDIV_EN
  task automatic test_muldiv();
    issue(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), 32'd6, 32'd7);  // MUL
    if (select !== 4'b1000 || busy !== 1'b0 || ready !== 1'b1) begin
      $display("FAIL mul got sel=%b busy=%b rdy=%b want 1000/0/1", select, busy, ready); n_fail++;
    end
    n_checks++;
    // DIV held 4 cycles while a younger ADD is offered and stall is raised
    issue(32'h0220C233, 32'd100, 32'd7);
    instr = 32'h002081B3; rs1_data = 32'd1; if_valid = 1'b1; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b1 || ready !== 1'b0 || idex_valid !== 1'b1) begin
        $display("FAIL div_hold%0d got busy=%b rdy=%b v=%b want 1/0/1", i, busy, ready, idex_valid);
        n_fail++;
      end
      n_checks++;
      if (select !== 4'b1001 || data1 !== 32'd100 || data2 !== 32'd7 || rd !== 5'd4) begin
        $display("FAIL div_frozen%0d got sel=%b d1=%h d2=%h rd=%0d want 1001/64/7/4",
                 i, select, data1, data2, rd);
        n_fail++;
      end
      n_checks++;
      if (i == 1) stall = 1'b0;
      step();
    end
    if (busy !== 1'b0 || idex_valid !== 1'b0 || ready !== 1'b1) begin
      $display("FAIL div_retire got busy=%b v=%b rdy=%b want 0/0/1", busy, idex_valid, ready);
      n_fail++;
    end
    n_checks++;
    if_valid = 1'b0;
    // flush in the second hold cycle
    issue(32'h0220C233, 32'd100, 32'd7);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (busy !== 1'b0 || idex_valid !== 1'b0 || ready !== 1'b1) begin
      $display("FAIL div_flush got busy=%b v=%b rdy=%b want 0/0/1", busy, idex_valid, ready);
      n_fail++;
    end
    n_checks++;
    // asynchronous reset mid-hold
    issue(32'h0220C233, 32'd100, 32'd7);
    step();
    #2 reset = 1'b0;
    #1;
    if (busy !== 1'b0 || idex_valid !== 1'b0 || data1 !== 32'd0 || select !== 4'd0) begin
      $display("FAIL rst_hold got busy=%b v=%b d1=%h sel=%b want 0", busy, idex_valid, data1, select);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (ready !== 1'b1) begin $display("FAIL rst_hold_ready got %b want 1", ready); n_fail++; end
    n_checks++;
  endtask
`else
  task automatic test_async_reset();
    issue(32'h002081B3, 32'd5, 32'd7);
    #2 reset = 1'b0;
    #1;
    if (idex_valid !== 1'b0 || data1 !== 32'd0 || data2 !== 32'd0 || reg_write !== 1'b0) begin
      $display("FAIL async_rst got v=%b d1=%h d2=%h we=%b want 0", idex_valid, data1, data2,
               reg_write);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (ready !== 1'b1) begin $display("FAIL async_rst_ready got %b want 1", ready); n_fail++; end
    n_checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_forward();
    test_illegal();
    test_stall_flush();
`ifdef ALU_ISSUE_MULDIV_EN
    test_muldiv();
`else
    test_async_reset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
